cau2_tdm_demux: RTL and testbench
=================================

// Module: cau2_tdm_demux
// PURPOSE
//  Receive end of the 8:1 gate-level multiplexer path: drives the mux select bus, samples the serial mux output Y
//  once per slot and rebuilds the 8-bit parallel word. A frame scans sel 0..N-1, then the assembled word is
//  presented with a one-cycle valid pulse. Sits beside the mux: sel -> mux S, mux Y -> y_in.
// PARAMETERS
//  SEL_W   3   width of select bus / slot counter
//  N       8   slots per frame; must equal 2**SEL_W
//  SETTLE  1   extra wait cycles after sel changes before sampling y_in (0 allowed; max 15)
// PORTS
//  clk     in   1      single clock, all logic rising-edge
//  rst     in   1      synchronous, active-high reset
//  start   in   1      begin a frame; sampled only in IDLE
//  cont    in   1      continuous mode: start next frame immediately after DONE, no gap
//  y_in    in   1      serial data from mux output Y
//  sel     out  SEL_W  select driven to mux S (registered)
//  data    out  N      last completed parallel word
//  valid   out  1      one-cycle pulse: data updated this cycle
//  busy    out  1      high while a frame is in progress
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high. Clock port clk, reset port rst.
//  Reset values: sel=0, data=0, valid=0, busy=0, state=IDLE, wait counter=0, shadow=0.
//  States: IDLE, SLOT.
//  IDLE: sel=0, busy=0. start=1 at edge -> SLOT, sel=0, wcnt=0.
//  SLOT: busy=1. Each edge: if wcnt<SETTLE, wcnt++; if wcnt==SETTLE, capture y_in into shadow[N-1-sel], wcnt=0:
//   - sel<N-1: sel++ (stay in SLOT)
//   - sel==N-1: data <= shadow with final bit merged, valid=1 next cycle; sel=0;
//     cont=1 -> remain SLOT (next frame, no idle cycle); cont=0 -> IDLE.
//  Bit mapping (fixed): slot k (sel=k) -> data[N-1-k]; sel=0 reads A[7], sel=7 reads A[0].
//  Timing: each slot lasts SETTLE+1 cycles. Start accepted at edge E0 -> last capture and data load at edge
//   E0+N*(SETTLE+1); valid high for exactly the following cycle. Default: 16 cycles per frame.
//  valid is never high for two consecutive cycles, also in cont mode with SETTLE=0 (frame >= N cycles).
//  start while busy: ignored, no effect on current frame. start and cont both high in IDLE: frame starts normally.
//  cont sampled only at final capture edge; dropping cont mid-frame ends after the current frame.
//  data holds its value between frames; only changes at a frame-complete edge.
//  rst mid-frame: all registers to reset values at that edge, partial shadow discarded, no valid pulse.
//  sel changes only at capture edges, so y_in is stable for >= SETTLE cycles before sampling.
// STRUCTURE
//  Shared constants header (`include): state encodings ST_IDLE/ST_SLOT, default SEL_W/N values,
//   shared with the mux test benches.
//  One sub-module: cau2_slot_timer -- SETTLE wait counter + SEL_W slot counter, outputs capture strobe,
//   last_slot flag, sel. Top keeps FSM, shadow register, data/valid outputs.
// TESTING (bench instantiates cau1_mux, sel->S, Y->y_in)
//  1. A=8'hA5, SETTLE=1, start pulse at E0 -> valid only in cycle after E0+16, data=8'hA5, busy low after.
//  2. Walking one A=8'h80, 8'h01 -> data=8'h80 and 8'h01 (checks sel=0 -> bit7 mapping).
//  3. SETTLE=0, cont=1, A=8'h3C for frame 1 then 8'hC3 -> valid pulses 8 cycles apart, data 8'h3C then 8'hC3.
//  4. start re-asserted at slot 3 of a frame with A=8'h5A -> single valid, data=8'h5A, frame length unchanged.
//  5. rst at slot 5 -> next cycle sel=0, data=0, busy=0, valid never pulses; new start gives a clean frame.
//  6. cont dropped mid-frame -> current frame completes with valid, then IDLE, sel=0.

Source files
------------

// File: rtl/cau2_tdm_demux_pkg.sv
// ----------------------------------------------------------------------------
// cau2_tdm_demux_pkg
// Shared constants for the TDM demultiplexer receive path and for the mux
// test benches: FSM state encodings, default select width, slot count,
// settle time and the width of the settle wait counter.
// ----------------------------------------------------------------------------
package cau2_tdm_demux_pkg;

   // Two-state receive FSM: idle between frames, scanning slots in a frame.
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SLOT = 1'b1
   } state_e;

   localparam int DEF_SEL_W  = 3;
   localparam int DEF_N      = 8;
   localparam int DEF_SETTLE = 1;

   // Settle counter width; supports SETTLE values 0..15.
   localparam int WCNT_W     = 4;

endpackage : cau2_tdm_demux_pkg

// File: rtl/cau2_slot_timer.sv
// ----------------------------------------------------------------------------
// cau2_slot_timer
// Slot timing for the TDM demultiplexer. While enabled, each slot lasts
// SETTLE+1 cycles: the wait counter runs 0..SETTLE and the capture strobe is
// high in the cycle where it equals SETTLE, at whose closing edge the slot
// counter (the registered mux select) advances and wraps from N-1 to 0.
// While disabled both counters are held at zero.
//
// Ports
//   clk          in   1      rising-edge clock
//   rst          in   1      synchronous active-high reset
//   en_i         in   1      frame in progress
//   capture_o    out  1      sample y_in at the coming edge
//   last_slot_o  out  1      current slot is N-1
//   sel_o        out  SEL_W  registered select to the mux
// ----------------------------------------------------------------------------
module cau2_slot_timer
   import cau2_tdm_demux_pkg::*;
#(
   parameter int SEL_W  = DEF_SEL_W,
   parameter int N      = DEF_N,
   parameter int SETTLE = DEF_SETTLE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   output logic             capture_o,
   output logic             last_slot_o,
   output logic [SEL_W-1:0] sel_o
);

   localparam logic [WCNT_W-1:0] SETTLE_C = WCNT_W'(SETTLE);
   localparam logic [SEL_W-1:0]  LAST_C   = SEL_W'(N - 1);

   logic [WCNT_W-1:0] wcnt_q;
   logic [WCNT_W-1:0] wcnt_d;
   logic [SEL_W-1:0]  sel_q;
   logic [SEL_W-1:0]  sel_d;
   logic              at_settle_s;
   logic              last_s;

   assign at_settle_s = (wcnt_q == SETTLE_C);
   assign last_s      = (sel_q == LAST_C);
   assign capture_o   = en_i & at_settle_s;
   assign last_slot_o = last_s;
   assign sel_o       = sel_q;

   // Next-state for the settle counter and the slot counter.
   always_comb begin
      wcnt_d = wcnt_q;
      sel_d  = sel_q;
      if (!en_i) begin
         wcnt_d = '0;
         sel_d  = '0;
      end else if (!at_settle_s) begin
         wcnt_d = wcnt_q + WCNT_W'(1);
         sel_d  = sel_q;
      end else begin
         // Capture edge: the select only ever moves here, so y_in has been
         // stable for the whole settle window before it is sampled.
         wcnt_d = '0;
         if (last_s) begin
            sel_d = '0;
         end else begin
            sel_d = sel_q + SEL_W'(1);
         end
      end
   end

   // Counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wcnt_q <= '0;
         sel_q  <= '0;
      end else begin
         wcnt_q <= wcnt_d;
         sel_q  <= sel_d;
      end
   end

endmodule : cau2_slot_timer

// File: rtl/cau2_tdm_demux.sv
// ----------------------------------------------------------------------------
// cau2_tdm_demux
// Receive end of the 8:1 multiplexer path. Drives the mux select, samples the
// serial mux output once per slot and rebuilds the parallel word. Slot k
// (sel=k) lands in data[N-1-k]. After the last slot the word is loaded into
// data and valid pulses for one cycle. In continuous mode the next frame
// begins immediately after the last capture.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous active-high reset
//   start  in   1      begin a frame (looked at only while idle)
//   cont   in   1      continuous mode (looked at only on the last capture)
//   y_in   in   1      serial data from the mux output
//   sel    out  SEL_W  registered select to the mux
//   data   out  N      last completed parallel word
//   valid  out  1      one-cycle pulse, data updated
//   busy   out  1      frame in progress
// ----------------------------------------------------------------------------
module cau2_tdm_demux
   import cau2_tdm_demux_pkg::*;
#(
   parameter int SEL_W  = DEF_SEL_W,
   parameter int N      = DEF_N,
   parameter int SETTLE = DEF_SETTLE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             cont,
   input  logic             y_in,
   output logic [SEL_W-1:0] sel,
   output logic [N-1:0]     data,
   output logic             valid,
   output logic             busy
);

   localparam logic [SEL_W-1:0] LAST_C = SEL_W'(N - 1);

   state_e           state_q;
   state_e           state_d;
   logic [N-1:0]     shadow_q;
   logic [N-1:0]     shadow_d;
   logic [N-1:0]     data_q;
   logic [N-1:0]     data_d;
   logic             valid_q;
   logic             valid_d;
   logic             busy_q;
   logic             busy_d;

   logic             capture_s;
   logic             last_slot_s;
   logic [SEL_W-1:0] sel_s;
   logic [SEL_W-1:0] bit_idx_s;
   logic [N-1:0]     merged_s;

   cau2_slot_timer #(
      .SEL_W  (SEL_W),
      .N      (N),
      .SETTLE (SETTLE)
   ) u_timer (
      .clk         (clk),
      .rst         (rst),
      .en_i        (state_q == ST_SLOT),
      .capture_o   (capture_s),
      .last_slot_o (last_slot_s),
      .sel_o       (sel_s)
   );

   // Slot k maps to bit N-1-k, so sel=0 delivers the MSB.
   assign bit_idx_s = LAST_C - sel_s;

   // Shadow word with the bit being captured this cycle already merged, so
   // the last slot can be loaded into data in the same edge.
   always_comb begin
      merged_s            = shadow_q;
      merged_s[bit_idx_s] = y_in;
   end

   // FSM next-state, shadow assembly and output next-state.
   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      data_d   = data_q;
      valid_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_SLOT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SLOT: begin
            if (capture_s) begin
               if (last_slot_s) begin
                  data_d   = merged_s;
                  valid_d  = 1'b1;
                  shadow_d = '0;
                  if (cont) begin
                     state_d = ST_SLOT;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  shadow_d = merged_s;
               end
            end else begin
               shadow_d = shadow_q;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            shadow_d = '0;
         end
      endcase
      busy_d = (state_d == ST_SLOT);
   end

   // State, shadow and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         shadow_q <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
      end
   end

   assign sel   = sel_s;
   assign data  = data_q;
   assign valid = valid_q;
   assign busy  = busy_q;

endmodule : cau2_tdm_demux

// File: tb/tb_cau2_tdm_demux.sv
// ----------------------------------------------------------------------------
// tb_cau2_tdm_demux
// Two receivers are exercised: u_dut1 with SETTLE=1 (16-cycle frames) and
// u_dut0 with SETTLE=0 (8-cycle frames). Each y_in is driven by a behavioural
// 8:1 mux model in which sel=0 selects A[7] and sel=7 selects A[0]. Expected
// words are queued when a frame is started and compared when valid pulses.
// ----------------------------------------------------------------------------
module tb_cau2_tdm_demux;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   // SETTLE=1 instance signals
   logic       rst1 = 1'b1, start1 = 1'b0, cont1 = 1'b0;
   logic [7:0] a1 = 8'h00;
   logic       y1;
   logic [2:0] sel1;
   logic [7:0] data1;
   logic       valid1, busy1;

   // SETTLE=0 instance signals
   logic       rst0 = 1'b1, start0 = 1'b0, cont0 = 1'b0;
   logic [7:0] a0 = 8'h00;
   logic       y0;
   logic [2:0] sel0;
   logic [7:0] data0;
   logic       valid0, busy0;

   // Mux model: sel=k drives A[7-k]
   assign y1 = a1[3'd7 - sel1];
   assign y0 = a0[3'd7 - sel0];

   cau2_tdm_demux #(.SEL_W(3), .N(8), .SETTLE(1)) u_dut1 (
      .clk(clk), .rst(rst1), .start(start1), .cont(cont1), .y_in(y1),
      .sel(sel1), .data(data1), .valid(valid1), .busy(busy1));

   cau2_tdm_demux #(.SEL_W(3), .N(8), .SETTLE(0)) u_dut0 (
      .clk(clk), .rst(rst0), .start(start0), .cont(cont0), .y_in(y0),
      .sel(sel0), .data(data0), .valid(valid0), .busy(busy0));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboards
   logic [7:0] sb1[$];
   logic [7:0] sb0[$];
   logic [7:0] e1, e0;
   logic       v1_prev = 1'b0, v0_prev = 1'b0;

   // Compare every valid pulse against the queued expectation
   always @(negedge clk) begin
      if (valid1) begin
         chk("valid1_not_back_to_back", {31'd0, v1_prev}, 32'd0);
         if (sb1.size() == 0) begin
            chk("sb1_unexpected_valid", 32'd1, 32'd0);
         end else begin
            e1 = sb1.pop_front();
            chk("data1", {24'd0, data1}, {24'd0, e1});
         end
      end
      if (valid0) begin
         chk("valid0_not_back_to_back", {31'd0, v0_prev}, 32'd0);
         if (sb0.size() == 0) begin
            chk("sb0_unexpected_valid", 32'd1, 32'd0);
         end else begin
            e0 = sb0.pop_front();
            chk("data0", {24'd0, data0}, {24'd0, e0});
         end
      end
      v1_prev = valid1;
      v0_prev = valid0;
   end

   typedef struct {
      logic [7:0] a;          // mux data word
      bit         cont;       // cont level at start
      int         restart_at; // negedge index to re-pulse start (0 = none)
      int         drop_at;    // negedge index to drop cont (0 = none)
      int         rst_at;     // negedge index to assert rst (0 = none)
      int         exp_valids; // valid pulses expected in the window
      int         exp_lat;    // negedge index of the valid pulse
      logic [7:0] exp_data;   // data held after the window
   } vec_t;

   vec_t vecs[8];

   // Run one SETTLE=1 frame; negedge n follows posedge E0+n-1
   task automatic run1(input vec_t v, input int idx);
      int vcount;
      int vfirst;
      string tag;
      vcount = 0;
      vfirst = 0;
      tag = $sformatf("v%0d", idx);
      @(negedge clk);
      a1 = v.a;
      start1 = 1'b1;
      cont1 = v.cont;
      if (v.exp_valids != 0) sb1.push_back(v.a);
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         start1 = (n == v.restart_at);
         if (n == v.drop_at) cont1 = 1'b0;
         if (valid1) begin
            vcount++;
            if (vfirst == 0) vfirst = n;
         end
         if (n == 1) chk({tag, "_busy_in_frame"}, {31'd0, busy1}, 32'd1);
         if (n == 7) chk({tag, "_sel_slot3"}, {29'd0, sel1}, 32'd3);
         if (v.rst_at != 0 && n == v.rst_at) rst1 = 1'b1;
         if (v.rst_at != 0 && n == v.rst_at + 1) begin
            chk({tag, "_rst_sel"}, {29'd0, sel1}, 32'd0);
            chk({tag, "_rst_data"}, {24'd0, data1}, 32'd0);
            chk({tag, "_rst_busy"}, {31'd0, busy1}, 32'd0);
            chk({tag, "_rst_valid"}, {31'd0, valid1}, 32'd0);
            rst1 = 1'b0;
         end
         if (v.exp_valids != 0 && n == v.exp_lat) begin
            chk({tag, "_busy_at_valid"}, {31'd0, busy1}, 32'd0);
         end
      end
      chk({tag, "_valid_count"}, vcount, v.exp_valids);
      if (v.exp_valids != 0) chk({tag, "_latency"}, vfirst, v.exp_lat);
      chk({tag, "_idle_busy"}, {31'd0, busy1}, 32'd0);
      chk({tag, "_idle_sel"}, {29'd0, sel1}, 32'd0);
      chk({tag, "_data_hold"}, {24'd0, data1}, {24'd0, v.exp_data});
   endtask

   int t0[4];
   int vc0;

   initial begin
      // a, cont, restart, drop, rst, valids, latency, data after
      vecs[0] = '{8'hA5, 1'b0, 0, 0, 0,  1, 17, 8'hA5};
      vecs[1] = '{8'h80, 1'b0, 0, 0, 0,  1, 17, 8'h80};
      vecs[2] = '{8'h01, 1'b0, 0, 0, 0,  1, 17, 8'h01};
      vecs[3] = '{8'h5A, 1'b0, 7, 0, 0,  1, 17, 8'h5A};
      vecs[4] = '{8'h33, 1'b0, 0, 0, 11, 0, 0,  8'h00};
      vecs[5] = '{8'h96, 1'b0, 0, 0, 0,  1, 17, 8'h96};
      vecs[6] = '{8'hE7, 1'b1, 0, 8, 0,  1, 17, 8'hE7};
      vecs[7] = '{8'h00, 1'b1, 0, 3, 0,  1, 17, 8'h00};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst1_sel", {29'd0, sel1}, 32'd0);
      chk("rst1_data", {24'd0, data1}, 32'd0);
      chk("rst1_valid", {31'd0, valid1}, 32'd0);
      chk("rst1_busy", {31'd0, busy1}, 32'd0);
      chk("rst0_sel", {29'd0, sel0}, 32'd0);
      chk("rst0_data", {24'd0, data0}, 32'd0);
      chk("rst0_busy", {31'd0, busy0}, 32'd0);
      rst1 = 1'b0;
      rst0 = 1'b0;
      @(negedge clk);
      chk("idle1_busy", {31'd0, busy1}, 32'd0);

      for (int i = 0; i < 8; i++) run1(vecs[i], i);

      // SETTLE=0 continuous: two back-to-back 8-cycle frames
      vc0 = 0;
      @(negedge clk);
      a0 = 8'h3C;
      start0 = 1'b1;
      cont0 = 1'b1;
      sb0.push_back(8'h3C);
      sb0.push_back(8'hC3);
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         start0 = 1'b0;
         if (valid0) begin
            if (vc0 < 4) t0[vc0] = n;
            vc0++;
         end
         if (n == 9) begin
            a0 = 8'hC3;
            cont0 = 1'b0;
         end
         if (n == 12) chk("cont_busy_frame2", {31'd0, busy0}, 32'd1);
      end
      chk("cont_valid_count", vc0, 2);
      chk("cont_valid1_time", t0[0], 9);
      chk("cont_valid2_time", t0[1], 17);
      chk("cont_idle_busy", {31'd0, busy0}, 32'd0);
      chk("cont_idle_sel", {29'd0, sel0}, 32'd0);
      chk("cont_data_hold", {24'd0, data0}, 32'hC3);

      chk("sb1_drained", sb1.size(), 0);
      chk("sb0_drained", sb0.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_cau2_tdm_demux
